// File: rtl/register_file_reader.sv
// 32 x WIDTH MIPS general register file: one write port, two combinational read ports and a
// handshaked debug dump engine. Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module register_file_reader #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr_a,
    output logic [WIDTH-1:0]      rd_data_a,
    input  logic [DEPTH_LOG2-1:0] rd_addr_b,
    output logic [WIDTH-1:0]      rd_data_b,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [DEPTH_LOG2-1:0] dump_index,
    output logic [WIDTH-1:0]      dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int DEPTH = 32'd1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    dump_state_t           state_r;
    logic                  dump_valid_r;
    logic                  dump_busy_r;
    logic                  dump_done_r;
    logic [DEPTH_LOG2-1:0] dump_index_r;

    logic [WIDTH-1:0] store_r [1:DEPTH-1];
    logic [WIDTH-1:0] entry_s [DEPTH];

    // Entry 0 has no storage and always reads as zero
    for (genvar g = 1; g < DEPTH; g++) begin : g_entry
        // One enabled register per architectural entry
        always_ff @(posedge clock) begin
            if (reset) begin
                store_r[g] <= '0;
            end else if (wr_en && (wr_addr == DEPTH_LOG2'(g))) begin
                store_r[g] <= wr_data;
            end else begin
                store_r[g] <= store_r[g];
            end
        end
    end

    // Architectural view of the file with the hardwired zero entry
    always_comb begin
        entry_s[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            entry_s[i] = store_r[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live_s;
    assign wr_live_s = wr_en && (wr_addr != '0);

    // Read ports and dump word with same-cycle forwarding of the writeback value
    always_comb begin
        rd_data_a = entry_s[rd_addr_a];
        rd_data_b = entry_s[rd_addr_b];
        dump_data = entry_s[dump_index_r];
        if (wr_live_s && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = entry_s[rd_addr_a];
        end
        if (wr_live_s && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = entry_s[rd_addr_b];
        end
        if (wr_live_s && (dump_index_r == wr_addr)) begin
            dump_data = wr_data;
        end else begin
            dump_data = entry_s[dump_index_r];
        end
    end
`else
    // Read ports and dump word return stored contents; a write lands the cycle after
    always_comb begin
        rd_data_a = entry_s[rd_addr_a];
        rd_data_b = entry_s[rd_addr_b];
        dump_data = entry_s[dump_index_r];
    end
`endif

    // Dump engine: IDLE -> SEND (one word per handshake) -> DONE (single pulse) -> IDLE
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
            dump_index_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    dump_done_r <= 1'b0;
                    if (dump_start) begin
                        state_r      <= SEND;
                        dump_valid_r <= 1'b1;
                        dump_busy_r  <= 1'b1;
                        dump_index_r <= '0;
                    end else begin
                        state_r      <= IDLE;
                        dump_valid_r <= 1'b0;
                        dump_busy_r  <= 1'b0;
                        dump_index_r <= '0;
                    end
                end
                SEND: begin
                    if (dump_ready && (dump_index_r == LAST_IDX)) begin
                        state_r      <= DONE;
                        dump_valid_r <= 1'b0;
                        dump_busy_r  <= 1'b0;
                        dump_done_r  <= 1'b1;
                        dump_index_r <= '0;
                    end else if (dump_ready) begin
                        dump_index_r <= dump_index_r + DEPTH_LOG2'(1);
                    end else begin
                        dump_index_r <= dump_index_r;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    dump_valid_r <= 1'b0;
                    dump_busy_r  <= 1'b0;
                    dump_done_r  <= 1'b0;
                    dump_index_r <= '0;
                end
                default: begin
                    state_r      <= IDLE;
                    dump_valid_r <= 1'b0;
                    dump_busy_r  <= 1'b0;
                    dump_done_r  <= 1'b0;
                    dump_index_r <= '0;
                end
            endcase
        end
    end

    assign dump_valid = dump_valid_r;
    assign dump_busy  = dump_busy_r;
    assign dump_done  = dump_done_r;
    assign dump_index = dump_index_r;

endmodule

// File: tb/tb_register_file_reader.sv
// Directed, scoreboard-based bench for register_file_reader; follows REGFILE_BYPASS_EN if defined.
module tb_register_file_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_index;
    logic [31:0] dump_data;
    logic        dump_busy;
    logic        dump_done;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    word_t       dump_q [$];

    register_file_reader dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic read_both(input logic [4:0] a, input logic [4:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        exp_q.push_back(model[a]);
        exp_q.push_back(model[b]);
        @(negedge clock);
        chk("rd_a", rd_data_a, exp_q.pop_front());
        chk("rd_b", rd_data_b, exp_q.pop_front());
        tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(dump_valid), 32'd0);
        chk({tag, "_busy"},  32'(dump_busy),  32'd0);
        chk({tag, "_done"},  32'(dump_done),  32'd0);
        chk({tag, "_index"}, 32'(dump_index), 32'd0);
    endtask

    initial begin
        int    accepted;
        int    dones;
        word_t w;

        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; dump_start = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state
        @(negedge clock);
        chk_idle("reset");
        tick();
        for (int i = 0; i < 32; i++) read_both(5'(i), 5'(31 - i));

        // 2: write to address 0 is discarded, address 7 is stored
        wr(5'd0, 32'hDEADBEEF);
        wr(5'd7, 32'h12345678);
        read_both(5'd0, 5'd7);

        // 3: same-cycle write and read of address 9
        rd_addr_a = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hA5A5A5A5);
`else
        exp_q.push_back(model[9]);
`endif
        @(negedge clock);
        chk("same_cycle_rd", rd_data_a, exp_q.pop_front());
        tick();
        wr_en = 1'b0;
        model[9] = 32'hA5A5A5A5;
        read_both(5'd9, 5'd0);
        // writing address 0 never forwards
        rd_addr_a = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        @(negedge clock);
        chk("wr0_fwd", rd_data_a, 32'd0);
        tick();
        wr_en = 1'b0;

        // 4: preload and zero-stall dump
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        for (int k = 0; k < 32; k++) dump_q.push_back('{idx: 5'(k), data: model[k]});
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            w = dump_q.pop_front();
            chk("d4_valid", 32'(dump_valid), 32'd1);
            chk("d4_busy",  32'(dump_busy),  32'd1);
            chk("d4_done",  32'(dump_done),  32'd0);
            chk("d4_index", 32'(dump_index), 32'(w.idx));
            chk("d4_data",  dump_data, w.data);
            tick();
        end
        dump_start = 1'b1;
        @(negedge clock);
        chk("d4_done_pulse", 32'(dump_done), 32'd1);
        chk("d4_done_valid", 32'(dump_valid), 32'd0);
        chk("d4_done_busy",  32'(dump_busy),  32'd0);
        chk("d4_done_index", 32'(dump_index), 32'd0);
        tick();
        dump_start = 1'b0;
        @(negedge clock);
        chk_idle("d4_after");
        dump_start = 1'b1;

        // 5: stalled dump with a write to the held word and an ignored restart
        for (int k = 0; k < 32; k++) dump_q.push_back('{idx: 5'(k), data: (k == 5) ? 32'hCAFEF00D : model[k]});
        tick();
        dump_start = 1'b0;
        accepted = 0;
        dones = 0;
        for (int c = 0; c < 110; c++) begin
            dump_ready = (c % 3 == 0);
            wr_en      = (c == 13);
            wr_addr    = 5'd5;
            wr_data    = 32'hCAFEF00D;
            dump_start = (c == 20);
            @(negedge clock);
            if (c == 14) begin
                chk("d5_stall_valid", 32'(dump_valid), 32'd1);
                chk("d5_stall_index", 32'(dump_index), 32'd5);
                chk("d5_stall_data",  dump_data, 32'hCAFEF00D);
            end
            if (dump_valid && dump_ready) begin
                accepted++;
                if (dump_q.size() > 0) begin
                    w = dump_q.pop_front();
                    chk("d5_index", 32'(dump_index), 32'(w.idx));
                    chk("d5_data",  dump_data, w.data);
                end else begin
                    chk("d5_extra_word", 32'(accepted), 32'd32);
                end
            end
            if (dump_done) dones++;
            tick();
        end
        wr_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        model[5] = 32'hCAFEF00D;
        chk("d5_words", 32'(accepted), 32'd32);
        chk("d5_dones", 32'(dones), 32'd1);
        chk("d5_left",  32'(dump_q.size()), 32'd0);
        read_both(5'd5, 5'd31);

        // 6: reset mid-dump and mid-write
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55555555;
        @(negedge clock);
        chk("d6_pre_index", 32'(dump_index), 32'd15);
        tick();
        reset = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clock);
        chk_idle("d6_reset");
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("d6_no_done", 32'(dump_done), 32'd0);
            read_both(5'(i), 5'(31 - i));
        end
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        @(negedge clock);
        chk("d6_restart_valid", 32'(dump_valid), 32'd1);
        chk("d6_restart_index", 32'(dump_index), 32'd0);
        chk("d6_restart_data",  dump_data, 32'd0);
        chk("d6_restart_busy",  32'(dump_busy),  32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
